// File: rtl/rv32_div_unit_pkg.sv
// Shared definitions for the RV32IM restoring divider.
package div_pkg;

    localparam int unsigned LEN   = 32;
    localparam int unsigned CNT_W = $clog2(LEN);

    localparam logic FUNC_DIV = 1'b0;
    localparam logic FUNC_REM = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/rv32_div_unit_if.sv
// Divider handshake bundle: the requester drives operands/start, the divider returns result/strobe.
interface rv32_div_unit_if import div_pkg::*; #(
    parameter int unsigned length = LEN
);
    logic signed [length-1:0] oper_a;
    logic signed [length-1:0] oper_b;
    logic                     fuct3;
    logic                     enable_div;
    logic signed [length-1:0] div_o;
    logic                     divided_by_zero;
    logic                     div_finish;

    modport master (
        output oper_a, oper_b, fuct3, enable_div,
        input  div_o, divided_by_zero, div_finish
    );

    modport slave (
        input  oper_a, oper_b, fuct3, enable_div,
        output div_o, divided_by_zero, div_finish
    );
endinterface

// File: rtl/rv32_div_unit_restore_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_restore_step #(
    parameter int unsigned length = 32
) (
    input  logic [length-1:0] rem_i,
    input  logic [length-1:0] quo_i,
    input  logic [length-1:0] divisor_i,
    output logic [length-1:0] rem_o,
    output logic [length-1:0] quo_o
);
    logic [length:0] shifted;
    logic [length:0] diff;

    always_comb begin
        // One extra bit keeps the shifted remainder exact even for a 2^(length-1) divisor.
        shifted = {rem_i, quo_i[length-1]};
        diff    = shifted - {1'b0, divisor_i};
        rem_o   = shifted[length-1:0];
        quo_o   = {quo_i[length-2:0], 1'b0};
        if (!diff[length]) begin
            rem_o    = diff[length-1:0];
            quo_o[0] = 1'b1;
        end
    end
endmodule

// File: rtl/rv32_div_unit.sv
// Multi-cycle signed divider: restoring iteration on magnitudes, sign fix-up, div-by-zero fast path.
module rv32_div_unit import div_pkg::*; #(
    parameter int unsigned length = LEN
) (
    input  logic            clk,
    input  logic            rst,
    rv32_div_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(length);

    div_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [length-1:0] rem_q, rem_d;
    logic [length-1:0] quo_q, quo_d;
    logic [length-1:0] absb_q, absb_d;
    logic              func_q, func_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [length-1:0] res_q, res_d;
    logic              dbz_q, dbz_d;
    logic              fin_q, fin_d;

    logic [length-1:0] step_rem, step_quo;
    logic [length-1:0] q_fix, r_fix;

    div_restore_step #(.length(length)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (absb_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            absb_q  <= '0;
            func_q  <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            absb_q  <= absb_d;
            func_q  <= func_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        absb_d  = absb_q;
        func_d  = func_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        fin_d   = 1'b0;

        // Fix-up works on the final step's outputs so the result lands in the same edge as DONE.
        q_fix = (sa_q ^ sb_q) ? (~step_quo + 1'b1) : step_quo;
        r_fix = sa_q ? (~step_rem + 1'b1) : step_rem;

        case (state_q)
            IDLE: begin
                if (bus.enable_div) begin
                    if (bus.oper_b == '0) begin
                        state_d = DONE;
                        res_d   = (bus.fuct3 == FUNC_REM) ? unsigned'(bus.oper_a) : '1;
                        dbz_d   = 1'b1;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        func_d  = bus.fuct3;
                        sa_d    = bus.oper_a[length-1];
                        sb_d    = bus.oper_b[length-1];
                        quo_d   = bus.oper_a[length-1] ? (~unsigned'(bus.oper_a) + 1'b1)
                                                       : unsigned'(bus.oper_a);
                        absb_d  = bus.oper_b[length-1] ? (~unsigned'(bus.oper_b) + 1'b1)
                                                       : unsigned'(bus.oper_b);
                        rem_d   = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(length - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    res_d   = (func_q == FUNC_REM) ? r_fix : q_fix;
                    fin_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.div_o           = res_q;
    assign bus.divided_by_zero = dbz_q;
    assign bus.div_finish      = fin_q;
endmodule

// File: tb/tb_rv32_div_unit.sv
// Self-checking bench for rv32_div_unit against a plain-arithmetic reference model.
module tb_rv32_div_unit;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rv32_div_unit_if #(.length(32)) bus ();

    rv32_div_unit #(.length(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M semantics from 64-bit signed arithmetic: truncating quotient, remainder follows dividend.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic f,
                                  output logic [31:0] v, output logic z);
        longint sa, sb;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (sb == 0) begin
            z = 1'b1;
            v = f ? a : 32'hFFFF_FFFF;
        end else begin
            z = 1'b0;
            v = f ? 32'(sa % sb) : 32'(sa / sb);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for div_finish; lat counts edges after the capture edge (0 means seen right after it).
    task automatic wait_finish(output int lat);
        lat = 0;
        while (bus.div_finish !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic f, input string tag);
        logic [31:0] ev;
        logic        ez;
        int          lat;
        model(a, b, f, ev, ez);
        bus.oper_a     = a;
        bus.oper_b     = b;
        bus.fuct3      = f;
        bus.enable_div = 1'b1;
        tick();
        bus.enable_div = 1'b0;
        bus.oper_a     = $urandom;
        bus.oper_b     = $urandom;
        bus.fuct3      = ~f;
        wait_finish(lat);
        check(32'(lat), (b == 0) ? 32'd0 : 32'd32, {tag, "_latency"});
        check(bus.div_o, ev, {tag, "_result"});
        check(32'(bus.divided_by_zero), 32'(ez), {tag, "_dbz"});
        tick();
        check(32'(bus.div_finish), 32'd0, {tag, "_strobe_one_cycle"});
        check(bus.div_o, ev, {tag, "_hold"});
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] ev;
        logic        ez;
        logic [31:0] ra, rb;
        logic        rf;

        bus.oper_a     = '0;
        bus.oper_b     = '0;
        bus.fuct3      = 1'b0;
        bus.enable_div = 1'b0;
        rst            = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check(bus.div_o, 32'd0, "reset_div_o");
        check(32'(bus.divided_by_zero), 32'd0, "reset_dbz");
        check(32'(bus.div_finish), 32'd0, "reset_finish");

        run_op(32'd100, 32'd7, FUNC_DIV, "div_100_7");
        run_op(32'd100, 32'd7, FUNC_REM, "rem_100_7");
        run_op(-32'sd100, 32'd7, FUNC_DIV, "div_m100_7");
        run_op(-32'sd100, 32'd7, FUNC_REM, "rem_m100_7");
        run_op(32'd100, -32'sd7, FUNC_DIV, "div_100_m7");
        run_op(32'd100, -32'sd7, FUNC_REM, "rem_100_m7");
        run_op(-32'sd100, -32'sd7, FUNC_DIV, "div_m100_m7");
        run_op(-32'sd100, -32'sd7, FUNC_REM, "rem_m100_m7");
        run_op(32'd5, 32'd0, FUNC_DIV, "div_by_zero");
        run_op(32'd5, 32'd0, FUNC_REM, "rem_by_zero");
        run_op(32'd9, 32'd3, FUNC_DIV, "after_zero");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, FUNC_DIV, "ovf_div");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, FUNC_REM, "ovf_rem");
        run_op(32'h8000_0000, 32'h8000_0000, FUNC_DIV, "min_by_min");
        run_op(32'd5, 32'd0, FUNC_REM, "pre_reset_zero");

        // Abort a running divide with a one-cycle reset.
        bus.oper_a     = 32'd1000;
        bus.oper_b     = 32'd3;
        bus.fuct3      = FUNC_DIV;
        bus.enable_div = 1'b1;
        tick();
        bus.enable_div = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check(bus.div_o, 32'd0, "midrst_div_o");
        check(32'(bus.divided_by_zero), 32'd0, "midrst_dbz");
        check(32'(bus.div_finish), 32'd0, "midrst_finish");
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.div_finish === 1'b1) seen++;
        end
        check(32'(seen), 32'd0, "midrst_no_finish");
        run_op(32'd9, 32'd3, FUNC_DIV, "after_reset");

        // Busy: operand changes during CALC are ignored; enable held through DONE re-triggers.
        bus.oper_a     = 32'd1234567;
        bus.oper_b     = 32'd89;
        bus.fuct3      = FUNC_DIV;
        bus.enable_div = 1'b1;
        tick();
        bus.oper_a = 32'd77;
        bus.oper_b = -32'sd5;
        bus.fuct3  = FUNC_REM;
        wait_finish(lat);
        model(32'd1234567, 32'd89, FUNC_DIV, ev, ez);
        check(32'(lat), 32'd32, "busy_latency");
        check(bus.div_o, ev, "busy_result");
        tick();
        check(32'(bus.div_finish), 32'd0, "busy_strobe_one_cycle");
        tick();
        bus.enable_div = 1'b0;
        wait_finish(lat);
        model(32'd77, -32'sd5, FUNC_REM, ev, ez);
        check(32'(lat), 32'd32, "retrigger_latency");
        check(bus.div_o, ev, "retrigger_result");
        tick();

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
            rf = 1'($urandom);
            run_op(ra, rb, rf, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
